uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle done pulse into a circular FIFO. It presents the oldest byte to the register/bus interface (show-ahead) and pops it on a read strobe. It also provides level, full/empty, sticky overrun and threshold-interrupt status to the UART register block.

Parameters:
DEPTH, 16, number of byte entries; power of 2, minimum 2
CW, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
rx_data_i  input  8  byte from receiver, valid when rx_done_i=1
rx_done_i  input  1  one-cycle push strobe from receiver
rd_en_i  input  1  pop strobe from bus side; one byte per high cycle
clr_i  input  1  synchronous flush of FIFO and status
rx_thresh_i  input  CW  interrupt threshold level; 0 disables
timeout_i  input  16  idle-timeout in clk cycles; 0 disables (used only with macro)
rd_data_o  output  8  head byte (show-ahead); 8'h00 when empty
count_o  output  CW  current occupancy, 0..DEPTH
empty_o  output  1  count_o==0
full_o  output  1  count_o==DEPTH
overrun_o  output  1  sticky: byte dropped due to full
thresh_irq_o  output  1  level interrupt: rx_thresh_i!=0 and count_o>=rx_thresh_i
timeout_o  output  1  idle-timeout interrupt (see Optional Feature)

Behaviour:
- Clock clk_i; reset rst_ni asynchronous, active-low. On reset: wr_ptr=rd_ptr=0, count_o=0, empty_o=1, full_o=0, overrun_o=0, thresh_irq_o=0, timeout_o=0, rd_data_o=8'h00. Storage contents are not reset.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is a separate CW-bit counter.
- Push (rx_done_i=1):
  - If not full, write rx_data_i at wr_ptr and increment wr_ptr.
  - If full and no pop in the same cycle, drop the byte and set overrun_o on the next edge.
- Pop (rd_en_i=1):
  - If not empty, increment rd_ptr. The new head appears on rd_data_o in the next cycle.
  - If empty, ignore: no pointer change, no error flag.
- Simultaneous push and pop:
  - Not empty and not full: both occur; count unchanged.
  - Full: pop frees a slot, so the push is accepted, count stays DEPTH, and no overrun.
  - Empty: pop ignored, push accepted, count becomes 1.
- rd_data_o is combinational from mem[rd_ptr], gated to 8'h00 when empty. Latency from push to visibility on rd_data_o/count_o is 1 cycle.
- count_o update: +1 on push-only accept, -1 on pop-only accept, otherwise unchanged. empty_o, full_o and thresh_irq_o are derived combinationally from the count register.
- clr_i has priority over push and pop in the same cycle. It resets pointers, count, overrun_o and the timeout state. A push coinciding with clr_i is discarded and does not set overrun.
- overrun_o stays high until clr_i or reset. Pops do not clear it.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any pending push is lost.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter clears to 0 on any accepted push, accepted pop, clr_i, when empty, or when timeout_i==0.
  - Otherwise it increments each cycle, saturating at timeout_i.
  - timeout_o=1 while the counter equals timeout_i (nonzero) and the FIFO is not empty. It clears the cycle after the next push, pop or clr_i.
- Not defined: counter not built, timeout_i unused, timeout_o tied 0. The port list is identical in both builds.

Test Plan:
- Reset then push 8'hA5, 8'h3C -> count_o=2, empty_o=0, rd_data_o=8'hA5. After one rd_en_i pulse -> rd_data_o=8'h3C, count_o=1.
- Push DEPTH bytes 0..15, then push 8'hFF -> full_o=1, overrun_o=1, count_o=16. Popping all 16 yields 0..15 in order, and 8'hFF never appears.
- FIFO full plus simultaneous push 8'h77 and pop -> count_o stays 16, overrun_o=0. 8'h77 is read last.
- Empty FIFO plus rd_en_i only -> no change, count_o=0, rd_data_o=8'h00. Empty plus push and pop together -> count_o=1.
- rx_thresh_i=4: push 3 -> thresh_irq_o=0; 4th push -> 1; one pop -> 0. Assert clr_i with a concurrent push -> count_o=0, overrun_o=0, empty_o=1.
- With UART_RX_TIMEOUT_EN and timeout_i=100: push one byte, then idle -> timeout_o rises 100 cycles after the push and clears the cycle after a pop. Without the macro, timeout_o stays 0 throughout.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: show-ahead head, level/status.
// Optional idle-timeout interrupt built only when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_done_i,
  input  logic          rd_en_i,
  input  logic          clr_i,
  input  logic [CW-1:0] rx_thresh_i,
  input  logic [15:0]   timeout_i,
  output logic [7:0]    rd_data_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          overrun_o,
  output logic          thresh_irq_o,
  output logic          timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovr_q;

  logic          empty;
  logic          full;
  logic          push_acc;
  logic          pop_acc;
  logic          drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_LVL);

  // A pop on a full FIFO frees the slot the push needs.
  assign pop_acc  = rd_en_i & ~empty;
  assign push_acc = rx_done_i & (~full | rd_en_i);
  assign drop     = rx_done_i & full & ~rd_en_i;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push_acc && !clr_i) begin
      mem[wr_ptr_q] <= rx_data_i;
    end
  end

  // Pointers, occupancy and sticky overrun; clr_i wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_acc) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign rd_data_o    = empty ? 8'h00 : mem[rd_ptr_q];
  assign count_o      = count_q;
  assign empty_o      = empty;
  assign full_o       = full;
  assign overrun_o    = ovr_q;
  assign thresh_irq_o = (rx_thresh_i != '0) &&
                        (count_q >= rx_thresh_i);

`ifdef UART_RX_TIMEOUT_EN
  logic [15:0] idle_q;
  logic        idle_rst;

  assign idle_rst = clr_i | push_acc | pop_acc |
                    empty | (timeout_i == 16'd0);

  // Idle counter saturates at the programmed timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_q <= '0;
    end else if (idle_rst) begin
      idle_q <= '0;
    end else if (idle_q >= timeout_i) begin
      idle_q <= timeout_i;
    end else begin
      idle_q <= idle_q + 16'd1;
    end
  end

  assign timeout_o = (timeout_i != 16'd0) &&
                     (idle_q == timeout_i) && !empty;
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_i;
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue scoreboard for popped bytes,
// directed status checks from the stimulus thread.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic          rd_en = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] thresh = '0;
  logic [15:0]   tmo = 16'd0;
  logic [7:0]    rd_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          ovr;
  logic          irq;
  logic          tout;

  int npass = 0;
  int ntotal = 0;
  logic [7:0] q[$];

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .rx_data_i    (rx_data),
    .rx_done_i    (rx_done),
    .rd_en_i      (rd_en),
    .clr_i        (clr),
    .rx_thresh_i  (thresh),
    .timeout_i    (tmo),
    .rd_data_o    (rd_data),
    .count_o      (count),
    .empty_o      (empty),
    .full_o       (full),
    .overrun_o    (ovr),
    .thresh_irq_o (irq),
    .timeout_o    (tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every accepted pop must show the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rd_en && !empty) begin
      if (q.size() == 0) begin
        ntotal++;
        $display("FAIL pop_unexpected: got %0h expected none", rd_data);
      end else begin
        chk("pop_data", {24'h0, rd_data}, {24'h0, q.pop_front()});
      end
    end
  end

  task automatic step(input logic p, input logic [7:0] d,
                      input logic r, input logic c);
    rx_done = p; rx_data = d; rd_en = r; clr = c;
    @(posedge clk); #1;
    rx_done = 0; rd_en = 0; clr = 0;
  endtask

  task automatic push(input logic [7:0] d);
    q.push_back(d);
    step(1, d, 0, 0);
  endtask

  task automatic pop();
    step(0, 8'h00, 1, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_irq", irq, 0);
    chk("rst_tout", tout, 0);
    chk("rst_data", rd_data, 8'h00);

    // basic push/pop
    push(8'hA5);
    push(8'h3C);
    chk("b_count", count, 2);
    chk("b_empty", empty, 0);
    chk("b_data", rd_data, 8'hA5);
    chk("b_irq_off", irq, 0);
    pop();
    chk("b_data2", rd_data, 8'h3C);
    chk("b_count2", count, 1);
    pop();
    chk("b_count3", count, 0);

    // fill, overflow drop, drain
    for (int i = 0; i < DEPTH; i++) push(8'(i));
    chk("f_full", full, 1);
    chk("f_count", count, 16);
    chk("f_ovr0", ovr, 0);
    step(1, 8'hFF, 0, 0);
    chk("f_full2", full, 1);
    chk("f_ovr", ovr, 1);
    chk("f_count2", count, 16);
    for (int i = 0; i < DEPTH; i++) pop();
    chk("f_drained", count, 0);
    chk("f_ovr_sticky", ovr, 1);
    step(0, 8'h00, 0, 1);
    chk("f_clr_ovr", ovr, 0);

    // full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
    q.push_back(8'h77);
    step(1, 8'h77, 1, 0);
    chk("s_count", count, 16);
    chk("s_ovr", ovr, 0);
    chk("s_head", rd_data, 8'h11);
    for (int i = 0; i < DEPTH; i++) pop();
    chk("s_empty", empty, 1);

    // empty cases
    pop();
    chk("e_count", count, 0);
    chk("e_data", rd_data, 8'h00);
    q.push_back(8'h5A);
    step(1, 8'h5A, 1, 0);
    chk("e_count1", count, 1);
    chk("e_data1", rd_data, 8'h5A);
    pop();
    chk("e_count0", count, 0);

    // threshold
    thresh = 5'd4;
    push(8'h01); push(8'h02); push(8'h03);
    chk("t_irq3", irq, 0);
    push(8'h04);
    chk("t_irq4", irq, 1);
    pop();
    chk("t_irq_pop", irq, 0);
    for (int i = 0; i < 13; i++) push(8'h40 + 8'(i));
    chk("t_full", full, 1);
    step(1, 8'hEE, 0, 0);
    chk("t_ovr", ovr, 1);
    q.delete();
    step(1, 8'hCC, 0, 1);
    chk("c_count", count, 0);
    chk("c_ovr", ovr, 0);
    chk("c_empty", empty, 1);
    chk("c_irq", irq, 0);
    thresh = '0;

    // idle timeout
    tmo = 16'd100;
    push(8'h9D);
`ifdef UART_RX_TIMEOUT_EN
    for (int i = 1; i <= 100; i++) begin
      step(0, 8'h00, 0, 0);
      if (i >= 99) chk("to_edge", tout, i == 100);
      else if (tout !== 1'b0) chk("to_early", tout, 0);
    end
    step(0, 8'h00, 0, 0);
    chk("to_hold", tout, 1);
    pop();
    chk("to_clear", tout, 0);
`else
    for (int i = 0; i < 110; i++) begin
      step(0, 8'h00, 0, 0);
      if (tout !== 1'b0 || i == 109) chk("to_off", tout, 0);
    end
    pop();
    chk("to_off_pop", tout, 0);
`endif
    tmo = 16'd0;
    chk("end_empty", empty, 1);
    chk("end_queue", q.size(), 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
